// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI request arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int DEFAULT_RETRY_LIMIT = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_priority_picker import spi_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] k;
    valid  = 1'b0;
    winner = '0;
    sum    = 0;
    k      = '0;
    // Scan from the farthest offset down so the nearest request is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      k = IDX_W'(sum);
      if (req[k]) begin
        valid  = 1'b1;
        winner = k;
      end
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// rtl/spi_request_arbiter.sv - round-robin arbiter sharing one SPI serializer among requesters
module spi_request_arbiter import spi_arb_pkg::*; #(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_SIZE   = 32,
  parameter int  RETRY_LIMIT = DEFAULT_RETRY_LIMIT,
  localparam int IDX_W       = idx_w(NUM_REQ)
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_n,
  input  logic [NUM_REQ-1:0]           i_Req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]           o_Ack,
  output logic [NUM_REQ-1:0]           o_Done,
  output logic                         o_Ser_Data_Ready,
  output logic [DATA_SIZE-1:0]         o_Ser_Data,
  input  logic                         i_Ser_Ready,
  output logic                         o_Busy,
  output logic [IDX_W-1:0]             o_Grant_Id,
  output logic                         o_Retry
);

  localparam int CNT_W = $clog2(RETRY_LIMIT + 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [CNT_W-1:0]     retry_cnt;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_id;
  logic [DATA_SIZE-1:0] req_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_words[g] = i_Req_Data[g*DATA_SIZE +: DATA_SIZE];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (i_Req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state            <= IDLE;
      ptr              <= '0;
      retry_cnt        <= '0;
      o_Ack            <= '0;
      o_Done           <= '0;
      o_Ser_Data_Ready <= 1'b0;
      o_Ser_Data       <= '0;
      o_Busy           <= 1'b0;
      o_Grant_Id       <= '0;
      o_Retry          <= 1'b0;
    end else begin
      o_Ack   <= '0;
      o_Done  <= '0;
      o_Retry <= 1'b0;
      case (state)
        // The serializer has no reset, so a launch waits until it reports ready.
        IDLE: begin
          if (pick_valid && i_Ser_Ready) begin
            o_Ser_Data       <= req_words[pick_id];
            o_Grant_Id       <= pick_id;
            o_Ack[pick_id]   <= 1'b1;
            o_Busy           <= 1'b1;
            o_Ser_Data_Ready <= 1'b1;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
          o_Ser_Data_Ready <= 1'b0;
          retry_cnt        <= '0;
          state            <= WAIT_BUSY;
        end
        // Ready staying high means the serializer missed the launch; relaunch the held word.
        WAIT_BUSY: begin
          if (!i_Ser_Ready) begin
            state <= WAIT_DONE;
          end else begin
            retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt + 1'b1 == CNT_W'(RETRY_LIMIT)) begin
              o_Ser_Data_Ready <= 1'b1;
              o_Retry          <= 1'b1;
              state            <= LAUNCH;
            end
          end
        end
        WAIT_DONE: begin
          if (i_Ser_Ready) begin
            o_Done[o_Grant_Id] <= 1'b1;
            o_Busy             <= 1'b0;
            ptr                <= (o_Grant_Id == IDX_W'(NUM_REQ - 1)) ? '0 : o_Grant_Id + 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb/tb_spi_request_arbiter.sv - directed and randomized bench for spi_request_arbiter
module tb_spi_request_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] data_arr [N];
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack, done;
  logic          ser_dr;
  logic [DW-1:0] ser_data;
  logic          ser_ready = 1'b1;
  logic          busy;
  logic [1:0]    grant_id;
  logic          retry;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*DW +: DW] = data_arr[g];
  end

  spi_request_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .RETRY_LIMIT(2)) dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_Req            (req),
    .i_Req_Data       (req_data),
    .o_Ack            (ack),
    .o_Done           (done),
    .o_Ser_Data_Ready (ser_dr),
    .o_Ser_Data       (ser_data),
    .i_Ser_Ready      (ser_ready),
    .o_Busy           (busy),
    .o_Grant_Id       (grant_id),
    .o_Retry          (retry)
  );

  // Serializer: no reset, shifts LSB-first and rebuilds the word; may ignore launches.
  logic [DW-1:0] ser_sh = '0, ser_word = '0, ser_last_word = '0;
  int ser_left = 0, ser_ignored = 0, ignore_budget = 0;
  always @(posedge clk) begin
    if (ser_ready) begin
      if (ser_dr) begin
        if (ser_ignored < ignore_budget) ser_ignored <= ser_ignored + 1;
        else begin
          ser_sh    <= ser_data;
          ser_left  <= DW;
          ser_ready <= 1'b0;
        end
      end
    end else begin
      ser_word <= {ser_sh[0], ser_word[DW-1:1]};
      ser_sh   <= ser_sh >> 1;
      ser_left <= ser_left - 1;
      if (ser_left == 1) begin
        ser_ready     <= 1'b1;
        ser_last_word <= {ser_sh[0], ser_word[DW-1:1]};
      end
    end
  end

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, retry_total = 0, last_retry_cyc = 0, ref_ptr = 0;
  int ack_total [N];
  int done_total [N];
  int grant_log [$];
  logic [N-1:0] req_at_edge = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    req_at_edge = req;
    @(posedge clk);
    #1;
    cyc++;
    if (ser_dr === 1'b1) chk("ready_while_ser_busy", ser_ready, 1);
    for (int k = 0; k < N; k++) begin
      if (ack[k] === 1'b1) ack_total[k]++;
      if (done[k] === 1'b1) done_total[k]++;
    end
    if (retry === 1'b1) begin
      retry_total++;
      last_retry_cyc = cyc;
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic raise(input int k);
    req[k] = 1'b1;
    data_arr[k] = $urandom;
  endtask

  task automatic serve_one(input string tag, input int exp_retry, input bit hold, input int collide);
    int t, w, ack_cyc, ack_c0, ret0;
    logic [DW-1:0] d;
    t = 0;
    while (ack === '0 && t < 200) begin step(); t++; end
    if (ack === '0) begin
      n_cmp++; n_fail++;
      $error("FAIL %s_ack_wait: observed no o_Ack expected one within 200 cycles", tag);
      return;
    end
    w = model_pick(req_at_edge, ref_ptr);
    if (w < 0) begin
      n_cmp++; n_fail++;
      $error("FAIL %s_spurious_ack: observed 0x%0h expected none", tag, ack);
      return;
    end
    d = data_arr[w];
    chk({tag, "_ack"}, ack, 64'(1) << w);
    chk({tag, "_grant_id"}, grant_id, w);
    chk({tag, "_data"}, ser_data, d);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_launch"}, ser_dr, 1);
    grant_log.push_back(w);
    ack_cyc = cyc;
    ack_c0 = ack_total[w];
    ret0 = retry_total;
    step();
    if (hold) data_arr[w] = $urandom;
    else req[w] = 1'b0;
    t = 0;
    while (done === '0 && t < 300) begin step(); t++; end
    if (done === '0) begin
      n_cmp++; n_fail++;
      $error("FAIL %s_done_wait: observed no o_Done expected one within 300 cycles", tag);
      return;
    end
    if (collide >= 0) raise(collide);
    chk({tag, "_done"}, done, 64'(1) << w);
    chk({tag, "_busy_clear"}, busy, 0);
    chk({tag, "_no_ack_at_done"}, ack, 0);
    chk({tag, "_serial_word"}, ser_last_word, d);
    chk({tag, "_single_ack"}, ack_total[w] - ack_c0, 0);
    chk({tag, "_retries"}, retry_total - ret0, exp_retry);
    if (exp_retry > 0) chk({tag, "_retry_time"}, last_retry_cyc - ack_cyc, 3);
    ref_ptr = (w + 1) % N;
  endtask

  initial begin
    int base, t, launches, w;
    for (int k = 0; k < N; k++) begin
      data_arr[k] = '0;
      ack_total[k] = 0;
      done_total[k] = 0;
    end

    repeat (3) step();
    chk("reset_outputs", {ack, done, ser_dr, ser_data, busy, grant_id, retry}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_ack", ack, 0);

    // Single requester, ack one cycle after the evaluating edge.
    data_arr[0] = 32'hA5A5_0F0F;
    req = 4'b0001;
    step();
    chk("single_ack_e1", ack, 4'b0001);
    serve_one("single", 0, 0, -1);
    repeat (3) step();
    chk("single_done_once", done_total[0], 1);
    chk("single_busy_after", busy, 0);

    // Fairness with every requester held high.
    for (int k = 0; k < N; k++) raise(k);
    base = grant_log.size();
    for (int i = 0; i < 8; i++) serve_one("fair", 0, 1, -1);
    req = '0;
    for (int i = 1; i < 8; i++) chk("fair_order", grant_log[base + i], (grant_log[base] + i) % N);

    // Pointer wrap after a grant to 3.
    raise(3);
    serve_one("wrap_pre", 0, 0, -1);
    raise(0);
    raise(3);
    serve_one("wrap", 0, 0, -1);
    chk("wrap_grant", grant_log[grant_log.size() - 1], 0);
    serve_one("wrap_post", 0, 0, -1);

    // Serializer drops the first launch.
    ignore_budget = ignore_budget + 1;
    raise(2);
    serve_one("lost", 1, 0, -1);

    // Requester 2 arrives in the o_Done cycle of requester 1.
    raise(1);
    serve_one("coll", 0, 0, 2);
    step();
    chk("coll_grant_delay", ack, 4'b0100);
    serve_one("coll2", 0, 0, -1);

    // Reset while the serializer is still shifting.
    raise(1);
    raise(2);
    t = 0;
    while (ack === '0 && t < 200) begin step(); t++; end
    w = model_pick(req_at_edge, ref_ptr);
    chk("rst_pre_grant", grant_id, w);
    step();
    req[1] = 1'b0;
    repeat (4) step();
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {ack, done, ser_dr, ser_data, busy, grant_id, retry}, 0);
    ref_ptr = 0;
    repeat (2) step();
    rst_n = 1'b1;
    t = 0;
    launches = 0;
    while (ser_ready !== 1'b1 && t < 100) begin
      step();
      if (ser_dr === 1'b1) launches++;
      t++;
    end
    chk("no_launch_before_ready", launches, 0);
    serve_one("after_rst", 0, 0, -1);

    // Randomized request mixes with occasional lost launches.
    for (int it = 0; it < 12; it++) begin
      logic [N-1:0] r;
      int er;
      r = N'($urandom_range(1, 15));
      er = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (er != 0) ignore_budget = ignore_budget + 1;
      for (int k = 0; k < N; k++) if (r[k] && !req[k]) raise(k);
      serve_one("rand", er, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_request_arbiter.md
# spi_request_arbiter

Round-robin arbiter that shares one SPI serializer between `NUM_REQ` requesters. It captures a requester's parallel word and launches exactly one serializer transfer per grant. It tracks completion through the serializer's ready handshake and reports per-requester acceptance and completion. It sits between the requesting blocks and the serializer's `i_Data_Ready` / `i_Data` / `o_Ready` interface.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_SIZE`, default 32: word width; must equal the serializer's `DATA_SIZE`.
- `RETRY_LIMIT`, default 2: cycles allowed in WAIT_BUSY before a relaunch.

Ports:
- `i_Clock`  in  1: single clock, shared with the serializer.
- `i_Reset_n`  in  1: asynchronous, active-low reset.
- `i_Req`  in  NUM_REQ: level request per requester; held until the matching `o_Ack`.
- `i_Req_Data`  in  NUM_REQ*DATA_SIZE: word k occupies bits [k*DATA_SIZE +: DATA_SIZE]; stable while `i_Req[k]` is high.
- `o_Ack`  out  NUM_REQ: one-cycle pulse when word k is captured.
- `o_Done`  out  NUM_REQ: one-cycle pulse when word k has finished shifting.
- `o_Ser_Data_Ready`  out  1: to the serializer's `i_Data_Ready`.
- `o_Ser_Data`  out  DATA_SIZE: to the serializer's `i_Data`.
- `i_Ser_Ready`  in  1: from the serializer's `o_Ready`.
- `o_Busy`  out  1: high from capture until `o_Done`.
- `o_Grant_Id`  out  clog2(NUM_REQ): index of the current or last grant.
- `o_Retry`  out  1: one-cycle pulse on each relaunch.

## Operation
- All outputs are registered. Reset value of every output is 0; the state resets to IDLE and the priority pointer to 0.
- States and transitions:
  - IDLE: if `|i_Req` and `i_Ser_Ready`, pick winner w, then:
    - capture the word of w into `o_Ser_Data`;
    - set `o_Grant_Id` = w;
    - pulse `o_Ack[w]`;
    - set `o_Busy` and `o_Ser_Data_Ready`;
    - go to LAUNCH.
  - LAUNCH: lasts one cycle, during which the serializer samples the request. Clear `o_Ser_Data_Ready`, clear the retry counter, go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `!i_Ser_Ready`, go to WAIT_DONE.
    - Otherwise increment the retry counter. When it reaches `RETRY_LIMIT`, set `o_Ser_Data_Ready`, pulse `o_Retry` and go to LAUNCH. The word is not recaptured and there is no new `o_Ack`.
  - WAIT_DONE: if `i_Ser_Ready`, pulse `o_Done[o_Grant_Id]`, clear `o_Busy`, set the pointer to `o_Grant_Id`+1 (mod NUM_REQ), go to IDLE.
- Round-robin pick: the first asserted `i_Req` bit scanning upward from the pointer, with wrap-around.
- A requester may drop or change `i_Req_Data` the cycle after its `o_Ack`. It may re-request immediately, but only wins after the other pending requesters have been served.
- Simultaneous events:
  - If `o_Done` and a new request coincide, the next grant is not issued that cycle. The earliest next grant is the cycle after return to IDLE.
  - `i_Req` deasserting in the same cycle as IDLE evaluation is honoured; that requester is not granted.
- Reset mid-operation: the arbiter returns to IDLE immediately. Because the serializer has no reset, no launch occurs until `i_Ser_Ready` is seen high. Any pending `o_Done` is lost.

## Timing
- Edge E: IDLE sees a request with `i_Ser_Ready` = 1.
- E+1: `o_Ack`, `o_Ser_Data_Ready` = 1 and data become valid.
- E+2: the serializer accepts; `o_Ser_Data_Ready` = 0; `i_Ser_Ready` falls after this edge.
- E+3: the arbiter enters WAIT_DONE.
- `o_Done` is asserted one cycle after `i_Ser_Ready` is seen high in WAIT_DONE.
- Minimum gap between successive `o_Ser_Data_Ready` pulses: serializer transfer length plus 3 cycles.
- `o_Ser_Data_Ready` is never high while `i_Ser_Ready` is low.

## Structure
- Package `spi_arb_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the `IDX_W` = clog2(NUM_REQ) helper;
  - the default `RETRY_LIMIT` constant.
- Sub-module `rr_priority_picker` is combinational. It takes the request vector and pointer and returns a valid flag and winner index. It is reused by other arbiters in the design.
- The FSM, capture register, retry counter and pointer live in `spi_request_arbiter`.

## Test plan
- **Single requester:** `i_Req` = 0001, data 0xA5A5_0F0F, serializer model present. Required response:
  - `o_Ack[0]` pulses at E+1;
  - the serial stream equals 0xA5A5_0F0F LSB-first;
  - `o_Done[0]` pulses once;
  - `o_Busy` = 0 afterwards.
- **Fairness:** all four requesters held high continuously. Grants follow the order 0,1,2,3,0,1,…; no requester is granted twice before the others are each served.
- **Pointer wrap:** last grant 3; then `i_Req` = 1001. The next grant is 0, not 3.
- **Lost accept:** the serializer model ignores the first `i_Data_Ready`. Required response:
  - `o_Retry` pulses after 2 cycles in WAIT_BUSY;
  - the same word is relaunched with no second `o_Ack`;
  - `o_Done` pulses once.
- **Reset mid-transfer:** assert `i_Reset_n` = 0 during WAIT_DONE. Required response:
  - all outputs go to 0 asynchronously;
  - after release, no `o_Ser_Data_Ready` until `i_Ser_Ready` = 1;
  - the pending request is then granted normally.
- **Done/request collision:** requester 2 asserts in the same cycle as `o_Done[1]`. The grant to 2 occurs the cycle after IDLE re-entry, and `o_Ser_Data_Ready` never overlaps `i_Ser_Ready` = 0.
